// File: rtl/m68k_bus_ctrl.sv
// 68000 asynchronous-bus slave controller: decodes the latched address into
// one-hot regions, inserts wait states, and answers with DTACK or a BERR timeout.
module m68k_bus_ctrl #(
   parameter int                        N_REGIONS   = 4,
   parameter logic [23*N_REGIONS-1:0]   REGION_BASE = '0,
   parameter logic [23*N_REGIONS-1:0]   REGION_MASK = '0,
   parameter logic [4*N_REGIONS-1:0]    REGION_WAIT = '0,
   parameter logic [N_REGIONS-1:0]      REGION_RO   = '0,
   parameter int                        BERR_CYCLES = 64
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      as_n,
   input  logic                      rw,
   input  logic                      uds_n,
   input  logic                      lds_n,
   input  logic [22:0]               addr,
   input  logic [N_REGIONS*16-1:0]   rdata,
   output logic [15:0]               cpu_din,
   output logic [N_REGIONS-1:0]      sel,
   output logic                      rd_stb,
   output logic                      wr_stb,
   output logic                      ub,
   output logic                      lb,
   output logic                      dtack_n,
   output logic                      berr_n
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_DECODE  = 3'd1;
   localparam logic [2:0] S_WAIT    = 3'd2;
   localparam logic [2:0] S_ACK     = 3'd3;
   localparam logic [2:0] S_TIMEOUT = 3'd4;
   localparam logic [2:0] S_BERR    = 3'd5;

   logic [2:0]           state_q, state_d;
   logic [22:0]          addr_q, addr_d;
   logic                 rw_q, rw_d;
   logic                 ub_q, ub_d;
   logic                 lb_q, lb_d;
   logic [N_REGIONS-1:0] sel_q, sel_d;
   logic                 rd_stb_q, rd_stb_d;
   logic                 wr_stb_q, wr_stb_d;
   logic                 dtack_n_q, dtack_n_d;
   logic                 berr_n_q, berr_n_d;
   logic [3:0]           wait_cnt_q, wait_cnt_d;
   logic [7:0]           to_cnt_q, to_cnt_d;

   logic [N_REGIONS-1:0] hit;
   logic [N_REGIONS-1:0] hit_sel;
   logic [3:0]           hit_wait;
   logic                 hit_ro;

   // Address compare against the latched address, one comparator per region
   generate
      for (genvar gi = 0; gi < N_REGIONS; gi++) begin : g_region
         assign hit[gi] = ((addr_q & REGION_MASK[23*gi +: 23]) ==
                           (REGION_BASE[23*gi +: 23] & REGION_MASK[23*gi +: 23]));
      end
   endgenerate

   // Scan high to low so the lowest-index hit is the one left standing
   always_comb begin
      hit_sel  = '0;
      hit_wait = 4'd0;
      hit_ro   = 1'b0;
      for (int i = N_REGIONS - 1; i >= 0; i--) begin
         if (hit[i]) begin
            hit_sel    = '0;
            hit_sel[i] = 1'b1;
            hit_wait   = REGION_WAIT[4*i +: 4];
            hit_ro     = REGION_RO[i];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      rw_d       = rw_q;
      ub_d       = ub_q;
      lb_d       = lb_q;
      sel_d      = sel_q;
      rd_stb_d   = 1'b0;
      wr_stb_d   = 1'b0;
      dtack_n_d  = dtack_n_q;
      berr_n_d   = berr_n_q;
      wait_cnt_d = wait_cnt_q;
      to_cnt_d   = to_cnt_q;
      case (state_q)
         S_IDLE: begin
            dtack_n_d = 1'b1;
            berr_n_d  = 1'b1;
            sel_d     = '0;
            if (!as_n) begin
               addr_d  = addr;
               rw_d    = rw;
               ub_d    = ~uds_n;
               lb_d    = ~lds_n;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (as_n) begin
               state_d = S_IDLE;
            end else if (|hit_sel) begin
               sel_d    = hit_sel;
               rd_stb_d = rw_q;
               wr_stb_d = ~rw_q & ~hit_ro;
               if (hit_wait == 4'd0) begin
                  dtack_n_d = 1'b0;
                  state_d   = S_ACK;
               end else begin
                  wait_cnt_d = hit_wait;
                  state_d    = S_WAIT;
               end
            end else begin
               to_cnt_d = 8'(BERR_CYCLES);
               state_d  = S_TIMEOUT;
            end
         end
         S_WAIT: begin
            if (as_n) begin
               sel_d      = '0;
               wait_cnt_d = 4'd0;
               state_d    = S_IDLE;
            end else if (wait_cnt_q == 4'd1) begin
               wait_cnt_d = 4'd0;
               dtack_n_d  = 1'b0;
               state_d    = S_ACK;
            end else begin
               wait_cnt_d = wait_cnt_q - 4'd1;
            end
         end
         S_ACK: begin
            if (as_n) begin
               dtack_n_d = 1'b1;
               sel_d     = '0;
               state_d   = S_IDLE;
            end
         end
         S_TIMEOUT: begin
            if (as_n) begin
               to_cnt_d = 8'd0;
               state_d  = S_IDLE;
            end else if (to_cnt_q == 8'd1) begin
               to_cnt_d = 8'd0;
               berr_n_d = 1'b0;
               state_d  = S_BERR;
            end else begin
               to_cnt_d = to_cnt_q - 8'd1;
            end
         end
         S_BERR: begin
            if (as_n) begin
               berr_n_d = 1'b1;
               state_d  = S_IDLE;
            end
         end
         default: begin
            dtack_n_d = 1'b1;
            berr_n_d  = 1'b1;
            sel_d     = '0;
            state_d   = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         rw_q       <= 1'b0;
         ub_q       <= 1'b0;
         lb_q       <= 1'b0;
         sel_q      <= '0;
         rd_stb_q   <= 1'b0;
         wr_stb_q   <= 1'b0;
         dtack_n_q  <= 1'b1;
         berr_n_q   <= 1'b1;
         wait_cnt_q <= 4'd0;
         to_cnt_q   <= 8'd0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         rw_q       <= rw_d;
         ub_q       <= ub_d;
         lb_q       <= lb_d;
         sel_q      <= sel_d;
         rd_stb_q   <= rd_stb_d;
         wr_stb_q   <= wr_stb_d;
         dtack_n_q  <= dtack_n_d;
         berr_n_q   <= berr_n_d;
         wait_cnt_q <= wait_cnt_d;
         to_cnt_q   <= to_cnt_d;
      end
   end

   // Read mux is driven straight off the registered select
   always_comb begin
      cpu_din = 16'hFFFF;
      for (int i = 0; i < N_REGIONS; i++) begin
         if (sel_q[i]) cpu_din = rdata[16*i +: 16];
      end
   end

   assign sel     = sel_q;
   assign rd_stb  = rd_stb_q;
   assign wr_stb  = wr_stb_q;
   assign ub      = ub_q;
   assign lb      = lb_q;
   assign dtack_n = dtack_n_q;
   assign berr_n  = berr_n_q;

endmodule

// File: tb/tb_m68k_bus_ctrl.sv
// Directed bench for m68k_bus_ctrl: four regions (overlap, wait states,
// read-only), unmapped timeout, abort and mid-access reset.
module tb_m68k_bus_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        as_n = 1'b1;
   logic        rw = 1'b1;
   logic        uds_n = 1'b1;
   logic        lds_n = 1'b1;
   logic [22:0] addr = '0;
   logic [63:0] rdata = 64'hDDDD_CCCC_BBBB_AAAA;
   logic [15:0] cpu_din;
   logic [3:0]  sel;
   logic        rd_stb, wr_stb, ub, lb, dtack_n, berr_n;

   int n_cmp = 0;
   int n_bad = 0;

   int          hs_cyc;
   logic        hs_berr;
   int          rd_n, wr_n;
   logic [3:0]  sel_or;
   logic [15:0] din_hs;
   logic        both_low;

   always #5 clk = ~clk;

   // r0: 0x000000/0x7F8000 w0; r1: 0x000000/0x7F0000 w2; r2: 0x100000 w3; r3: 0x200000 w1 RO
   m68k_bus_ctrl #(
      .N_REGIONS  (4),
      .REGION_BASE({23'h200000, 23'h100000, 23'h000000, 23'h000000}),
      .REGION_MASK({23'h7F0000, 23'h7F0000, 23'h7F0000, 23'h7F8000}),
      .REGION_WAIT({4'd1, 4'd3, 4'd2, 4'd0}),
      .REGION_RO  (4'b1000),
      .BERR_CYCLES(8)
   ) dut (
      .clk(clk), .reset(reset), .as_n(as_n), .rw(rw), .uds_n(uds_n), .lds_n(lds_n),
      .addr(addr), .rdata(rdata), .cpu_din(cpu_din), .sel(sel), .rd_stb(rd_stb),
      .wr_stb(wr_stb), .ub(ub), .lb(lb), .dtack_n(dtack_n), .berr_n(berr_n)
   );

   // Starts an access and records what the DUT does until the first handshake.
   // Cycle k is sampled on the k-th falling edge after as_n was driven low.
   task automatic do_access(input logic [22:0] a, input logic r, input logic u,
                            input logic l, input int max_cyc);
      hs_cyc = -1; hs_berr = 1'b0; rd_n = 0; wr_n = 0;
      sel_or = '0; din_hs = '0; both_low = 1'b0;
      @(negedge clk);
      as_n = 1'b0; addr = a; rw = r; uds_n = u; lds_n = l;
      for (int k = 1; k <= max_cyc; k++) begin
         @(negedge clk);
         rd_n += int'(rd_stb);
         wr_n += int'(wr_stb);
         sel_or |= sel;
         if (!dtack_n && !berr_n) both_low = 1'b1;
         if (!dtack_n || !berr_n) begin
            hs_cyc  = k;
            hs_berr = !berr_n;
            din_hs  = cpu_din;
            break;
         end
      end
   endtask

   task automatic release_bus();
      as_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({dtack_n, berr_n, sel, rd_stb, wr_stb, ub, lb} !== {1'b1, 1'b1, 4'b0, 4'b0}) begin
         n_bad++;
         $display("FAIL reset_outputs: got dtack_n=%b berr_n=%b sel=%b rd=%b wr=%b ub=%b lb=%b, expected 1 1 0000 0 0 0 0",
                  dtack_n, berr_n, sel, rd_stb, wr_stb, ub, lb);
      end
      n_cmp++;
      if (cpu_din !== 16'hFFFF) begin
         n_bad++;
         $display("FAIL reset_cpu_din: got %h expected ffff", cpu_din);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_zero_wait_read();
      do_access(23'h000010, 1'b1, 1'b0, 1'b0, 20);
      $display("zero-wait read: hs_cyc=%0d sel=%b din=%h rd=%0d", hs_cyc, sel_or, din_hs, rd_n);
      n_cmp++;
      if (hs_cyc !== 2 || hs_berr !== 1'b0) begin
         n_bad++;
         $display("FAIL zw_latency: got cycle %0d berr=%b expected dtack at cycle 2", hs_cyc, hs_berr);
      end
      n_cmp++;
      if (sel_or !== 4'b0001 || din_hs !== 16'hAAAA) begin
         n_bad++;
         $display("FAIL zw_sel_din: got sel=%b din=%h expected 0001 aaaa", sel_or, din_hs);
      end
      n_cmp++;
      if (rd_n !== 1 || wr_n !== 0 || ub !== 1'b1 || lb !== 1'b1) begin
         n_bad++;
         $display("FAIL zw_strobes: got rd=%0d wr=%0d ub=%b lb=%b expected 1 0 1 1", rd_n, wr_n, ub, lb);
      end
      release_bus();
   endtask

   task automatic test_wait_write();
      logic held;
      do_access(23'h100002, 1'b0, 1'b0, 1'b1, 20);
      $display("wait-state write: hs_cyc=%0d sel=%b wr=%0d", hs_cyc, sel_or, wr_n);
      n_cmp++;
      if (hs_cyc !== 5 || hs_berr !== 1'b0) begin
         n_bad++;
         $display("FAIL ws_latency: got cycle %0d berr=%b expected dtack at cycle 5", hs_cyc, hs_berr);
      end
      n_cmp++;
      if (sel_or !== 4'b0100 || wr_n !== 1 || rd_n !== 0 || ub !== 1'b1 || lb !== 1'b0) begin
         n_bad++;
         $display("FAIL ws_sel_strobe: got sel=%b wr=%0d rd=%0d ub=%b lb=%b expected 0100 1 0 1 0",
                  sel_or, wr_n, rd_n, ub, lb);
      end
      held = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (dtack_n !== 1'b0 || wr_stb !== 1'b0) held = 1'b0;
      end
      n_cmp++;
      if (held !== 1'b1) begin
         n_bad++;
         $display("FAIL ws_dtack_hold: got dtack dropped or extra wr_stb expected dtack_n held 0");
      end
      release_bus();
      n_cmp++;
      if (dtack_n !== 1'b1 || sel !== 4'b0000) begin
         n_bad++;
         $display("FAIL ws_release: got dtack_n=%b sel=%b expected 1 0000", dtack_n, sel);
      end
   endtask

   task automatic test_unmapped();
      do_access(23'h7FFFFF, 1'b1, 1'b0, 1'b0, 30);
      $display("unmapped read: hs_cyc=%0d berr=%b sel=%b", hs_cyc, hs_berr, sel_or);
      n_cmp++;
      if (hs_cyc !== 10 || hs_berr !== 1'b1 || both_low !== 1'b0) begin
         n_bad++;
         $display("FAIL um_berr: got cycle %0d berr=%b both_low=%b expected berr at cycle 10 alone",
                  hs_cyc, hs_berr, both_low);
      end
      n_cmp++;
      if (sel_or !== 4'b0000 || rd_n !== 0 || wr_n !== 0 || din_hs !== 16'hFFFF) begin
         n_bad++;
         $display("FAIL um_quiet: got sel=%b rd=%0d wr=%0d din=%h expected 0000 0 0 ffff",
                  sel_or, rd_n, wr_n, din_hs);
      end
      release_bus();
      n_cmp++;
      if (berr_n !== 1'b1 || dtack_n !== 1'b1) begin
         n_bad++;
         $display("FAIL um_release: got berr_n=%b dtack_n=%b expected 1 1", berr_n, dtack_n);
      end
   endtask

   task automatic test_ro_write();
      do_access(23'h200004, 1'b0, 1'b0, 1'b0, 20);
      $display("read-only write: hs_cyc=%0d sel=%b wr=%0d", hs_cyc, sel_or, wr_n);
      n_cmp++;
      if (hs_cyc !== 3 || hs_berr !== 1'b0) begin
         n_bad++;
         $display("FAIL ro_ack: got cycle %0d berr=%b expected dtack at cycle 3", hs_cyc, hs_berr);
      end
      n_cmp++;
      if (wr_n !== 0 || rd_n !== 0 || sel_or !== 4'b1000) begin
         n_bad++;
         $display("FAIL ro_no_wr: got wr=%0d rd=%0d sel=%b expected 0 0 1000", wr_n, rd_n, sel_or);
      end
      release_bus();
   endtask

   task automatic test_overlap_abort();
      logic quiet;
      do_access(23'h000020, 1'b1, 1'b0, 1'b0, 20);
      $display("overlap read: hs_cyc=%0d sel=%b din=%h", hs_cyc, sel_or, din_hs);
      n_cmp++;
      if (sel_or !== 4'b0001 || hs_cyc !== 2 || din_hs !== 16'hAAAA) begin
         n_bad++;
         $display("FAIL ov_priority: got sel=%b cycle %0d din=%h expected 0001 2 aaaa", sel_or, hs_cyc, din_hs);
      end
      release_bus();
      // Region 1 alone (wait 2): abort while in WAIT
      @(negedge clk);
      as_n = 1'b0; addr = 23'h009000; rw = 1'b1; uds_n = 1'b0; lds_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      $display("abort access: sel=%b din=%h rd_stb=%b", sel, cpu_din, rd_stb);
      n_cmp++;
      if (sel !== 4'b0010 || rd_stb !== 1'b1 || cpu_din !== 16'hBBBB) begin
         n_bad++;
         $display("FAIL ab_wait: got sel=%b rd=%b din=%h expected 0010 1 bbbb", sel, rd_stb, cpu_din);
      end
      as_n = 1'b1;
      quiet = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (dtack_n !== 1'b1 || berr_n !== 1'b1 || sel !== 4'b0000 || rd_stb !== 1'b0) quiet = 1'b0;
      end
      n_cmp++;
      if (quiet !== 1'b1) begin
         n_bad++;
         $display("FAIL ab_no_handshake: got a handshake or select after abort expected none");
      end
   endtask

   task automatic test_reset_mid_wait();
      @(negedge clk);
      as_n = 1'b0; addr = 23'h100002; rw = 1'b1; uds_n = 1'b0; lds_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if (sel !== 4'b0100) begin
         n_bad++;
         $display("FAIL rst_pre: got sel=%b expected 0100", sel);
      end
      reset = 1'b1;
      as_n = 1'b1;
      @(negedge clk);
      $display("reset mid-wait: dtack_n=%b berr_n=%b sel=%b", dtack_n, berr_n, sel);
      n_cmp++;
      if ({dtack_n, berr_n, sel, rd_stb, wr_stb, ub, lb} !== {1'b1, 1'b1, 4'b0, 4'b0} ||
          cpu_din !== 16'hFFFF) begin
         n_bad++;
         $display("FAIL rst_mid: got dtack_n=%b berr_n=%b sel=%b rd=%b wr=%b ub=%b lb=%b din=%h expected 1 1 0000 0 0 0 0 ffff",
                  dtack_n, berr_n, sel, rd_stb, wr_stb, ub, lb, cpu_din);
      end
      reset = 1'b0;
      repeat (2) begin
         @(negedge clk);
         n_cmp++;
         if (dtack_n !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_no_ack: got dtack_n=%b expected 1", dtack_n);
         end
      end
      do_access(23'h000010, 1'b1, 1'b1, 1'b0, 20);
      $display("post-reset read: hs_cyc=%0d sel=%b din=%h", hs_cyc, sel_or, din_hs);
      n_cmp++;
      if (hs_cyc !== 2 || din_hs !== 16'hAAAA || rd_n !== 1 || ub !== 1'b0 || lb !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_after: got cycle %0d din=%h rd=%0d ub=%b lb=%b expected 2 aaaa 1 0 1",
                  hs_cyc, din_hs, rd_n, ub, lb);
      end
      release_bus();
   endtask

   task automatic test_back_to_back();
      do_access(23'h200000, 1'b1, 1'b0, 1'b0, 20);
      $display("b2b first: hs_cyc=%0d din=%h", hs_cyc, din_hs);
      n_cmp++;
      if (hs_cyc !== 3 || din_hs !== 16'hDDDD || rd_n !== 1) begin
         n_bad++;
         $display("FAIL b2b_first: got cycle %0d din=%h rd=%0d expected 3 dddd 1", hs_cyc, din_hs, rd_n);
      end
      as_n = 1'b1;
      do_access(23'h000004, 1'b1, 1'b0, 1'b0, 20);
      $display("b2b second: hs_cyc=%0d din=%h", hs_cyc, din_hs);
      n_cmp++;
      if (hs_cyc !== 2 || din_hs !== 16'hAAAA || sel_or !== 4'b0001) begin
         n_bad++;
         $display("FAIL b2b_second: got cycle %0d din=%h sel=%b expected 2 aaaa 0001", hs_cyc, din_hs, sel_or);
      end
      release_bus();
   endtask

   initial begin
      test_reset();
      test_zero_wait_read();
      test_wait_write();
      test_unmapped();
      test_ro_write();
      test_overlap_abort();
      test_reset_mid_wait();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
